mcu_stripe_reader: RTL

- Downstream neighbour of the HM01B0 ingester.
- Once the ingester fills one 8-row stripe in the double-buffered EBR bank, this block reads that stripe back out of the back buffer, one 8x8 MCU at a time.
- Each MCU is emitted in raster order (py, then px) as a valid/ready byte stream to the DCT stage.
- It raises a sticky overrun flag if the ingester finishes the next stripe before readout completes.

---
 rtl/mcu_stripe_reader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mcu_stripe_reader.sv
// mcu_stripe_reader: reads one completed 8-row stripe out of the back half of
// the double-buffered EBR bank as a sequence of 8x8 MCUs, each in raster
// order, and streams the bytes to the DCT stage over valid/ready.
// Optional build macro MCU_STRIPE_READER_CYCLE_COUNT_EN adds stripe_cycles,
// the number of busy cycles spent on the most recent stripe.
module mcu_stripe_reader #(
   parameter int WIDTH_PIX = 320,
   parameter int NUM_EBR   = 5,
   parameter int EBR_SIZE  = 512
) (
   input  logic                       clock,
   input  logic                       nreset,
   input  logic                       frontbuffer_select,
   output logic [$clog2(NUM_EBR)-1:0] rd_block_select,
   output logic                       rd_buffer_select,
   output logic [$clog2(EBR_SIZE)-1:0] rd_addr,
   output logic                       rd_en,
   input  logic [7:0]                 rd_data,
   output logic [7:0]                 pix_data,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic                       pix_first,
   output logic                       pix_last,
   output logic [5:0]                 mcu_index,
   output logic                       stripe_done,
   output logic                       overrun,
   input  logic                       overrun_clear
`ifdef MCU_STRIPE_READER_CYCLE_COUNT_EN
   ,
   output logic [15:0]                stripe_cycles
`endif
);

   localparam int MCUS = WIDTH_PIX / 8;
   localparam int BW   = $clog2(NUM_EBR);
   localparam int AW   = $clog2(EBR_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   // One output beat; metadata rides along with the byte through the skid FIFO.
   typedef struct packed {
      logic [7:0] data;
      logic       first;
      logic       last;
      logic [5:0] mcu;
   } beat_t;

   state_t      r_state, w_state_nxt;
   logic        r_fb_prev, w_stripe_evt;
   logic [2:0]  r_px, r_py, r_slot;
   logic [5:0]  r_m;
   logic [BW-1:0] r_blk;
   logic        r_buf_sel, r_overrun;
   logic        r_inflight, r_if_first, r_if_last;
   logic [5:0]  r_if_mcu;
   beat_t       r_q [2];
   logic [1:0]  r_occ;
   beat_t       w_in, w_head;
   logic        w_issue, w_clear_cnt, w_last_rd;
   logic        w_accept, w_pop, w_push, w_widx;

   assign w_stripe_evt = (frontbuffer_select != r_fb_prev);
   assign w_last_rd    = (r_m == 6'(MCUS-1)) && (r_py == 3'd7) && (r_px == 3'd7);

   // State register.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state, read issue (credit-limited so the 2-entry FIFO never overflows).
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_clear_cnt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_stripe_evt) begin
               w_state_nxt = S_READ;
               w_clear_cnt = 1'b1;
            end
         end
         S_READ: begin
            w_issue = ((r_occ + {1'b0, r_inflight}) < 2'd2);
            if (w_issue && w_last_rd) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_occ == 2'd0 && !r_inflight) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Edge detector, buffer latch and read-position counters (block index is a
   // wrap counter so no divider is needed for m % NUM_EBR and m / NUM_EBR).
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_fb_prev <= 1'b0;
         r_buf_sel <= 1'b0;
         r_px      <= '0;
         r_py      <= '0;
         r_m       <= '0;
         r_blk     <= '0;
         r_slot    <= '0;
      end else begin
         r_fb_prev <= frontbuffer_select;
         if (w_clear_cnt) begin
            r_buf_sel <= r_fb_prev;
            r_px      <= '0;
            r_py      <= '0;
            r_m       <= '0;
            r_blk     <= '0;
            r_slot    <= '0;
         end else if (w_issue) begin
            r_px <= r_px + 3'd1;
            if (r_px == 3'd7) begin
               r_py <= r_py + 3'd1;
               if (r_py == 3'd7) begin
                  r_m <= r_m + 6'd1;
                  if (r_blk == BW'(NUM_EBR-1)) begin
                     r_blk  <= '0;
                     r_slot <= r_slot + 3'd1;
                  end else begin
                     r_blk <= r_blk + BW'(1);
                  end
               end
            end
         end
      end
   end

   // Track the single outstanding read and the metadata its data will carry.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_inflight <= 1'b0;
         r_if_first <= 1'b0;
         r_if_last  <= 1'b0;
         r_if_mcu   <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_if_first <= (r_px == 3'd0) && (r_py == 3'd0);
            r_if_last  <= (r_px == 3'd7) && (r_py == 3'd7);
            r_if_mcu   <= r_m;
         end
      end
   end

   assign rd_en           = w_issue;
   assign rd_block_select = r_blk;
   assign rd_buffer_select = r_buf_sel;
   assign rd_addr         = AW'({r_slot, r_py, r_px});

   // Returning data bypasses the FIFO when it is empty, giving 1 beat/clock
   // and first valid two cycles after the stripe event.
   assign w_in      = '{data: rd_data, first: r_if_first, last: r_if_last, mcu: r_if_mcu};
   assign pix_valid = (r_occ != 2'd0) || r_inflight;
   assign w_head    = (r_occ != 2'd0) ? r_q[0] : (r_inflight ? w_in : '0);
   assign w_accept  = pix_valid && pix_ready;
   assign w_pop     = w_accept && (r_occ != 2'd0);
   assign w_push    = r_inflight && !(w_accept && r_occ == 2'd0);
   assign w_widx    = w_pop ? (r_occ == 2'd2) : (r_occ == 2'd1);

   assign pix_data    = w_head.data;
   assign pix_first   = w_head.first;
   assign pix_last    = w_head.last;
   assign mcu_index   = w_head.mcu;
   assign stripe_done = w_accept && w_head.last && (w_head.mcu == 6'(MCUS-1));

   // Two-entry skid FIFO; entry 0 is the head.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_occ <= '0;
         for (int i = 0; i < 2; i++) r_q[i] <= '0;
      end else begin
         if (w_pop)  r_q[0] <= r_q[1];
         if (w_push) r_q[w_widx] <= w_in;
         r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Sticky overrun: a new stripe arrived while still busy; set beats clear.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)                              r_overrun <= 1'b0;
      else if (w_stripe_evt && r_state != S_IDLE) r_overrun <= 1'b1;
      else if (overrun_clear)                   r_overrun <= 1'b0;
   end

   assign overrun = r_overrun;

`ifdef MCU_STRIPE_READER_CYCLE_COUNT_EN
   logic [15:0] r_cyc_cnt, r_stripe_cycles, w_cyc_inc;

   assign w_cyc_inc = (r_cyc_cnt == 16'hFFFF) ? r_cyc_cnt : r_cyc_cnt + 16'd1;

   // Busy-cycle counter; the snapshot includes the stripe_done cycle itself.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_cyc_cnt       <= '0;
         r_stripe_cycles <= '0;
      end else begin
         if (r_state == S_IDLE && w_stripe_evt) r_cyc_cnt <= '0;
         else if (r_state != S_IDLE)            r_cyc_cnt <= w_cyc_inc;
         if (stripe_done) r_stripe_cycles <= w_cyc_inc;
      end
   end

   assign stripe_cycles = r_stripe_cycles;
`endif

endmodule
